// File: rtl/tcs34725_reader.sv
// tcs34725_reader: free-running I2C master that powers up a TCS34725 and
// repeatedly burst-reads its clear/red/green/blue channels.
module tcs34725_reader #(
  parameter int          CLK_HZ    = 50_000_000,
  parameter int          I2C_HZ    = 100_000,
  parameter logic [6:0]  DEV_ADDR  = 7'h29,
  parameter logic [7:0]  ATIME     = 8'hF6,
  parameter int          PON_WAIT  = 150_000,
  parameter int          POLL_WAIT = 1_250_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        sda_in,
  output logic        scl_oe,
  output logic        sda_oe,
  output logic [15:0] clear,
  output logic [15:0] red,
  output logic [15:0] green,
  output logic [15:0] blue,
  output logic        data_valid,
  output logic        nack,
  output logic        busy
);
  localparam int Q    = CLK_HZ / (4 * I2C_HZ);
  localparam int QW   = Q > 1 ? $clog2(Q) : 1;
  localparam int WMAX = PON_WAIT > POLL_WAIT ? PON_WAIT : POLL_WAIT;
  localparam int WW   = $clog2(WMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_WPON, S_POLL, S_START, S_BIT, S_STOP, S_FIN} state_t;
  typedef enum logic [1:0] {T_PON, T_EN, T_AT, T_RD} txn_t;

  state_t        state;
  txn_t          txn, go_txn;
  logic [QW-1:0] cnt;
  logic [WW-1:0] wcnt;
  logic [1:0]    q;
  logic [3:0]    b, bi;
  logic [7:0]    sh;
  logic [63:0]   shd;
  logic          nk, abt, init_done, tick, rd, go, wdone;

  function automatic logic [7:0] wbyte(input txn_t t, input logic [3:0] i);
    return i == 4'd0 ? {DEV_ADDR, 1'b0} :
           i == 4'd1 ? (t == T_RD ? 8'hB4 : t == T_AT ? 8'h81 : 8'h80) :
           t == T_RD ? {DEV_ADDR, 1'b1} : t == T_PON ? 8'h01 : t == T_EN ? 8'h03 : ATIME;
  endfunction

  assign tick   = cnt == QW'(Q - 1);
  assign rd     = bi > 4'd2;
  assign busy   = state != S_IDLE;
  assign wdone  = wcnt == (state == S_WPON ? WW'(PON_WAIT - 1) : WW'(POLL_WAIT - 1));
  assign go     = (state == S_IDLE && en) || ((state == S_WPON || state == S_POLL) && wdone) ||
                  (state == S_FIN && !abt && txn == T_EN);
  assign go_txn = state == S_WPON ? T_EN : state == S_FIN ? T_AT : init_done ? T_RD : T_PON;

  // Byte index bi: 0 addr+W, 1 cmd, 2 data or addr+R, 3..10 read bytes.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= S_IDLE;
      txn        <= T_PON;
      cnt        <= '0;
      wcnt       <= '0;
      q          <= '0;
      b          <= '0;
      bi         <= '0;
      sh         <= '0;
      shd        <= '0;
      nk         <= 1'b0;
      abt        <= 1'b0;
      init_done  <= 1'b0;
      scl_oe     <= 1'b0;
      sda_oe     <= 1'b0;
      clear      <= '0;
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      data_valid <= 1'b0;
      nack       <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + 1'b1;
      data_valid <= 1'b0;
      nack       <= 1'b0;
      case (state)
        S_WPON, S_POLL: if (!wdone) wcnt <= wcnt + 1'b1;
        S_START: if (tick) begin
          q <= q + 1'b1;
          case (q)
            2'd0: sda_oe <= 1'b0;
            2'd1: scl_oe <= 1'b0;
            2'd2: sda_oe <= 1'b1;
            default: begin
              scl_oe <= 1'b1;
              state  <= S_BIT;
              b      <= '0;
              sh     <= wbyte(txn, bi);
            end
          endcase
        end
        S_BIT: if (tick) begin
          q <= q + 1'b1;
          case (q)
            2'd0: sda_oe <= b[3] ? (rd && bi != 4'd10) : (!rd && !sh[7]);
            2'd1: scl_oe <= 1'b0;
            2'd2: if (b[3]) nk <= sda_in & ~rd; else sh <= {sh[6:0], sda_in};
            default: begin
              scl_oe <= 1'b1;
              b      <= b + 1'b1;
              if (b[3]) begin
                b <= '0;
                if (nk) begin
                  abt   <= 1'b1;
                  state <= S_STOP;
                end else begin
                  if (rd) shd <= {sh, shd[63:8]};
                  if (bi == 4'd10 || (txn != T_RD && bi == 4'd2)) state <= S_STOP;
                  else if (txn == T_RD && bi == 4'd1) begin
                    state <= S_START;
                    bi    <= 4'd2;
                  end else begin
                    bi <= bi + 4'd1;
                    sh <= wbyte(txn, bi + 4'd1);
                  end
                end
              end
            end
          endcase
        end
        S_STOP: if (tick) begin
          q <= q + 1'b1;
          case (q)
            2'd0: sda_oe <= 1'b1;
            2'd1: scl_oe <= 1'b0;
            2'd2: begin
              sda_oe <= 1'b0;
              state  <= S_FIN;
              q      <= '0;
            end
            default: ;
          endcase
        end
        S_FIN: begin
          wcnt <= '0;
          if (abt) begin
            nack      <= 1'b1;
            init_done <= 1'b0;
            state     <= en ? S_POLL : S_IDLE;
          end else case (txn)
            T_PON: state <= S_WPON;
            T_EN:  ;
            T_AT: begin
              init_done <= 1'b1;
              state     <= en ? S_POLL : S_IDLE;
            end
            default: begin
              data_valid <= 1'b1;
              clear      <= shd[15:0];
              red        <= shd[31:16];
              green      <= shd[47:32];
              blue       <= shd[63:48];
              state      <= en ? S_POLL : S_IDLE;
            end
          endcase
        end
        default: ;
      endcase
      if (go) begin
        state <= S_START;
        txn   <= go_txn;
        cnt   <= '0;
        q     <= '0;
        bi    <= '0;
        abt   <= 1'b0;
      end
    end
endmodule

// File: tb/tb_tcs34725_reader.sv
// tb_tcs34725_reader: directed bench with an I2C slave model standing in for the sensor.
module tb_tcs34725_reader;
  localparam int PON_WAIT  = 40;
  localparam int POLL_WAIT = 60;

  logic        clk = 1'b0, rst = 1'b0, en = 1'b0, drv = 1'b0;
  logic        scl_oe, sda_oe, data_valid, nack, busy, scl, sda;
  logic [15:0] clear, red, green, blue;
  int          checks = 0, errors = 0;

  logic [7:0]  txd [8];
  logic [7:0]  rxb = 8'h00, mack = 8'h00;
  logic [7:0]  wq [$];
  logic [7:0]  init_exp [9];
  int          st_cyc [$], sp_cyc [$];
  int          cyc = 0, starts = 0, stops = 0, dv_cnt = 0, nack_cnt = 0, tx_bytes = 0;
  int          bitn = 0, txi = 0, s, bb, d;
  logic        pscl = 1'b1, psda = 1'b1, mode = 1'b0, first = 1'b0, nack_next = 1'b0;

  assign scl = ~scl_oe;
  assign sda = ~sda_oe & ~drv;

  always #5 clk = ~clk;

  tcs34725_reader #(
    .CLK_HZ(800), .I2C_HZ(100), .PON_WAIT(PON_WAIT), .POLL_WAIT(POLL_WAIT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sda_in(sda),
    .scl_oe(scl_oe), .sda_oe(sda_oe),
    .clear(clear), .red(red), .green(green), .blue(blue),
    .data_valid(data_valid), .nack(nack), .busy(busy)
  );

  // Slave model and pulse counters, evaluated just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (data_valid) dv_cnt++;
    if (nack) nack_cnt++;
    if (pscl && scl && psda && !sda) begin
      starts++;
      st_cyc.push_back(cyc);
      bitn = 0; mode = 1'b0; first = 1'b1; drv = 1'b0;
    end else if (pscl && scl && !psda && sda) begin
      stops++;
      sp_cyc.push_back(cyc);
      bitn = 0; mode = 1'b0; drv = 1'b0;
    end else if (!pscl && scl) begin
      if (bitn < 8) begin
        if (!mode) rxb = {rxb[6:0], sda};
      end else if (mode) mack = {mack[6:0], sda};
      bitn++;
    end else if (pscl && !scl) begin
      if (bitn == 8) begin
        if (mode) drv = 1'b0;
        else begin
          wq.push_back(rxb);
          drv = !(first && nack_next);
          if (first) nack_next = 1'b0;
        end
      end else if (bitn == 9) begin
        bitn = 0;
        drv  = 1'b0;
        if (!mode && first && rxb[0]) begin
          mode = 1'b1; txi = 0; tx_bytes++;
          drv = !txd[0][7];
        end else if (mode && !mack[0]) begin
          txi++; tx_bytes++;
          drv = !txd[txi][7];
        end else mode = 1'b0;
        first = 1'b0;
      end else if (mode) drv = !txd[txi][7-bitn];
    end
    pscl = scl;
    psda = ~sda_oe & ~drv;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_stops(input int n);
    for (int i = 0; i < 5000 && stops < n; i++) @(negedge clk);
    chk("stop_timeout", 64'(stops >= n), 64'd1);
  endtask

  task automatic wait_dv(input int n);
    for (int i = 0; i < 5000 && dv_cnt < n; i++) @(negedge clk);
    chk("dv_timeout", 64'(dv_cnt >= n), 64'd1);
  endtask

  task automatic wait_txb(input int n);
    for (int i = 0; i < 5000 && tx_bytes < n; i++) @(negedge clk);
    chk("txbyte_timeout", 64'(tx_bytes >= n), 64'd1);
  endtask

  task automatic chk_wq(input string tag, input logic [23:0] exp);
    chk(tag, wq.size() == 3 ? 64'({wq[0], wq[1], wq[2]}) : 64'hxxxx, 64'(exp));
  endtask

  initial begin
    init_exp = '{8'h52, 8'h80, 8'h01, 8'h52, 8'h80, 8'h03, 8'h52, 8'h81, 8'hF6};
    txd = '{8'h10, 8'h02, 8'h34, 8'h01, 8'h78, 8'h00, 8'h9A, 8'h00};
    en = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outputs", {clear, red, green, blue}, 0);
    chk("rst_dv_nack", {data_valid, nack}, 0);
    rst = 1'b1;

    wait_stops(3);
    chk("init_count", wq.size(), 9);
    for (int i = 0; i < 9; i++) chk($sformatf("init_byte%0d", i), wq[i], init_exp[i]);
    chk("pon_gap", 64'((st_cyc.size() > 1 && sp_cyc.size() > 0) ? (st_cyc[1] - sp_cyc[0] >= PON_WAIT) : 0), 1);
    chk("init_no_dv", dv_cnt, 0);

    wq.delete();
    s = starts;
    wait_dv(1);
    chk("read1_sample", {clear, red, green, blue}, 64'h0210_0134_0078_009A);
    chk("read1_bytes", wq.size() == 3 ? 64'({wq[0], wq[1], wq[2]}) : 64'hxxxx, 64'h52B453);
    chk("read1_starts", starts - s, 2);
    chk("read1_master_acks", mack, 8'h01);
    @(negedge clk);
    chk("read1_dv_width", {data_valid, 32'(dv_cnt)}, {1'b0, 32'd1});

    txd = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    wq.delete();
    s = stops;
    wait_stops(s + 1);
    chk("read2_hold", {clear, red, green, blue}, 64'h0210_0134_0078_009A);
    chk("read2_hold_dv", dv_cnt, 1);
    @(negedge clk);
    chk("read2_sample", {clear, red, green, blue}, 64'h2211_4433_6655_8877);
    chk("read2_dv", {data_valid, 32'(dv_cnt)}, {1'b1, 32'd2});
    chk_wq("read2_no_init", 24'h52B453);

    nack_next = 1'b1;
    wq.delete();
    for (int i = 0; i < 5000 && nack_cnt < 1; i++) @(negedge clk);
    chk("nack_seen", nack_cnt, 1);
    chk("nack_bytes", wq.size() == 1 ? 64'(wq[0]) : 64'hxxxx, 64'h52);
    chk("nack_outputs", {clear, red, green, blue}, 64'h2211_4433_6655_8877);
    chk("nack_no_dv", dv_cnt, 2);
    @(negedge clk);
    chk("nack_width", {nack, 32'(nack_cnt)}, {1'b0, 32'd1});
    wq.delete();
    s = stops;
    wait_stops(s + 1);
    chk_wq("reinit_pon", 24'h528001);

    wait_stops(s + 3);
    txd = '{8'hA5, 8'h5A, 8'h0F, 8'hF0, 8'h01, 8'h80, 8'hFE, 8'h7F};
    bb = tx_bytes;
    wait_txb(bb + 3);
    en = 1'b0;
    wait_dv(3);
    chk("endrop_sample", {clear, red, green, blue}, 64'h5AA5_F00F_8001_7FFE);
    chk("endrop_idle", {busy, scl_oe, sda_oe}, 3'b000);
    s = starts;
    repeat (200) @(negedge clk);
    chk("endrop_stays_idle", {busy, 32'(starts - s)}, 33'd0);
    en = 1'b1;
    wq.delete();
    s = stops;
    wait_stops(s + 1);
    chk_wq("resume_no_init", 24'h52B453);
    wait_dv(4);
    chk("resume_sample", {clear, red, green, blue}, 64'h5AA5_F00F_8001_7FFE);

    bb = tx_bytes;
    wait_txb(bb + 5);
    repeat (10) @(negedge clk);
    d = dv_cnt;
    chk("pre_reset_active", {busy, scl_oe}, 2'b11);
    rst = 1'b0;
    #1;
    chk("midreset_lines", {scl_oe, sda_oe}, 2'b00);
    chk("midreset_outputs", {clear, red, green, blue}, 0);
    chk("midreset_busy", busy, 0);
    repeat (20) @(negedge clk);
    chk("midreset_no_dv", {data_valid, 32'(dv_cnt - d)}, 33'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
